// File: rtl/zx_clk_reset_ce.sv
// zx_clk_reset_ce
//   Reset and clock-enable generator for the ZX81 core on the 52 MHz system
//   clock (PLL outclk_0). The PLL lock flag is synchronised and turned into a
//   clean core reset. The reset is held for HOLD_CYCLES clocks after lock or
//   after a soft reset request. While the core runs, the block produces
//   single-cycle enables at 13 MHz, 6.5 MHz and 3.25 MHz.
//
// Parameters
//   HOLD_CYCLES  clocks that sys_rst stays high after lock or soft reset (>=1)
//   HOLD_W       hold counter width, 2**HOLD_W > HOLD_CYCLES
//
// Ports
//   clk           in   52 MHz system clock
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock flag, asynchronous to clk
//   soft_rst_req  in   synchronous one-cycle core reset request
//   turbo         in   CPU double speed (only with ZX_CE_TURBO_EN)
//   sys_rst       out  synchronous active-high core reset
//   ce_13m        out  enable, 1 of every 4 clk
//   ce_6m5        out  enable, 1 of every 8 clk
//   ce_cpu        out  CPU enable, 1 of every 16 clk (1 of 8 in turbo)
//
// Build option
//   ZX_CE_TURBO_EN  adds the turbo port. The turbo setting is sampled on
//                   16-cycle boundaries, so the CPU rate never changes in the
//                   middle of a window.

module zx_clk_reset_ce #(
  parameter int unsigned HOLD_CYCLES = 65536,
  parameter int unsigned HOLD_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_rst_req,
`ifdef ZX_CE_TURBO_EN
  input  logic turbo,
`endif
  output logic sys_rst,
  output logic ce_13m,
  output logic ce_6m5,
  output logic ce_cpu
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic              sync1_q;
  logic              lock_s_q;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        phase_q, phase_d;
  logic              run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous soft reset request.
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // The phase restarts at 0 on every entry into RUN.
  always_comb begin
    phase_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      phase_d = phase_q + 4'd1;
    end
  end

`ifdef ZX_CE_TURBO_EN
  logic turbo_q, turbo_d;

  // Sample turbo only on a window boundary, or at any time while the core is
  // held in reset, so that a CPU cycle is never shortened.
  always_comb begin
    turbo_d = turbo_q;
    if (state_q != RUN || phase_q == 4'hF) begin
      turbo_d = turbo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turbo_q <= 1'b0;
    end else begin
      turbo_q <= turbo_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      phase_q  <= '0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Outputs are decoded only from registers. Leaving RUN drops every enable
  // on the same cycle that sys_rst rises.
  assign run     = (state_q == RUN);
  assign sys_rst = !run;
  assign ce_13m  = run && (phase_q[1:0] == 2'b11);
  assign ce_6m5  = run && (phase_q[2:0] == 3'b111);
`ifdef ZX_CE_TURBO_EN
  assign ce_cpu  = run && (turbo_q ? (phase_q[2:0] == 3'b111) : (phase_q == 4'hF));
`else
  assign ce_cpu  = run && (phase_q == 4'hF);
`endif

endmodule
